// File: rtl/glitch_pulse_gen.sv
// Glitch pulse generator: synchronises an asynchronous trigger and, once armed,
// waits a latched delay and then emits a train of pulses of latched width, count
// and spacing on a registered output.
module glitch_pulse_gen #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             trigger_i,
  input  logic [WIDTH-1:0] delay_i,
  input  logic [WIDTH-1:0] width_i,
  input  logic [WIDTH-1:0] gap_i,
  input  logic [WIDTH-1:0] repeat_i,
  output logic             glitch_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StDelay,
    StPulse,
    StGap,
    StDone
  } state_t;

  state_t                 r_state;
  state_t                 w_state_d;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_det;

  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       w_cnt_d;
  logic [WIDTH-1:0]       r_pulses;
  logic [WIDTH-1:0]       w_pulses_d;
  logic [WIDTH-1:0]       w_pulses_inc;

  // Latched programming; width/gap stored minus one so a 0 request maps to 1 cycle
  logic [WIDTH-1:0]       r_delay;
  logic [WIDTH-1:0]       r_width_m1;
  logic [WIDTH-1:0]       r_gap_m1;
  logic [WIDTH-1:0]       r_repeat;
  logic                   w_latch;

  logic                   r_glitch;
  logic                   r_busy;
  logic                   r_done;

  // Rising edge of the synchronised trigger; prev tracks it in every state
  assign w_det        = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_pulses_inc = r_pulses + WIDTH'(1);

  // Trigger synchroniser and edge register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], trigger_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Capture the programming on an accepted arm
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_delay    <= '0;
      r_width_m1 <= '0;
      r_gap_m1   <= '0;
      r_repeat   <= '0;
    end else if (w_latch) begin
      r_delay    <= delay_i;
      r_width_m1 <= (width_i == '0) ? '0 : width_i - WIDTH'(1);
      r_gap_m1   <= (gap_i == '0) ? '0 : gap_i - WIDTH'(1);
      r_repeat   <= (repeat_i == '0) ? WIDTH'(1) : repeat_i;
    end
  end

  // Next-state, phase counter and pulse counter
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_pulses_d = r_pulses;
    w_latch    = 1'b0;
    if (abort_i) begin
      w_state_d  = StIdle;
      w_cnt_d    = '0;
      w_pulses_d = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (arm_i) begin
            w_latch    = 1'b1;
            w_state_d  = StArmed;
            w_cnt_d    = '0;
            w_pulses_d = '0;
          end
        end
        StArmed: begin
          if (w_det) begin
            w_state_d = StDelay;
            w_cnt_d   = '0;
          end
        end
        StDelay: begin
          if (r_cnt == r_delay) begin
            w_state_d = StPulse;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + WIDTH'(1);
          end
        end
        StPulse: begin
          if (r_cnt == r_width_m1) begin
            w_cnt_d    = '0;
            w_pulses_d = w_pulses_inc;
            w_state_d  = (w_pulses_inc == r_repeat) ? StDone : StGap;
          end else begin
            w_cnt_d = r_cnt + WIDTH'(1);
          end
        end
        StGap: begin
          if (r_cnt == r_gap_m1) begin
            w_state_d = StPulse;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + WIDTH'(1);
          end
        end
        StDone: begin
          w_state_d  = StIdle;
          w_pulses_d = '0;
        end
        default: begin
          w_state_d  = StIdle;
          w_cnt_d    = '0;
          w_pulses_d = '0;
        end
      endcase
    end
  end

  // State, counters and outputs, all registered from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_pulses <= '0;
      r_glitch <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_pulses <= w_pulses_d;
      r_glitch <= (w_state_d == StPulse);
      r_busy   <= (w_state_d != StIdle);
      r_done   <= (w_state_d == StDone);
    end
  end

  assign glitch_o = r_glitch;
  assign busy_o   = r_busy;
  assign done_o   = r_done;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Scoreboard bench for glitch_pulse_gen: stimulus computes every expected glitch/done
// cycle from the timing rules and queues it; a monitor pops on each asserted output.
module tb_glitch_pulse_gen;

  localparam int W    = 32;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         arm;
  logic         abort;
  logic         trig;
  logic [W-1:0] dly;
  logic [W-1:0] wid;
  logic [W-1:0] gap;
  logic [W-1:0] rep;
  logic         glitch;
  logic         busy;
  logic         done;

  glitch_pulse_gen #(
    .WIDTH      (W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .arm_i    (arm),
    .abort_i  (abort),
    .trigger_i(trig),
    .delay_i  (dly),
    .width_i  (wid),
    .gap_i    (gap),
    .repeat_i (rep),
    .glitch_o (glitch),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  // cyc == N when observed after active edge N
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    bit d;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic take(input bit kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got 1 want 0 (cycle %0d)", kind ? "done" : "glitch", cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_cycle", cyc, e.c);
      chk("event_kind", int'(kind), int'(e.d));
    end
  endtask

  // Monitor: every asserted output cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (glitch) take(1'b0);
    if (done) take(1'b1);
  end

  // kill: 0 none, 1 abort, 2 reset; asserted at negedge cyc == D + kill_k
  task automatic run_txn(input int d, input int w, input int g, input int r,
                         input int kill, input int kill_k, input bit pre_high, input bit poke);
    int we, ge, re, e0, dd, done_c, kill_e, end_c, st;
    ev_t ev;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    re = (r == 0) ? 1 : r;
    if (pre_high) begin
      @(negedge clk);
      trig = 1'b1;
      repeat (4) @(negedge clk);
    end
    @(negedge clk);
    dly = W'(d); wid = W'(w); gap = W'(g); rep = W'(r);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    // Later changes must be ignored by the latched block
    dly = W'($urandom_range(0, 40)); wid = W'($urandom_range(0, 40));
    gap = W'($urandom_range(0, 40)); rep = W'($urandom_range(0, 40));
    if (pre_high) begin
      repeat (8) @(negedge clk);
      trig = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    trig   = 1'b1;
    e0     = cyc + 1;
    dd     = e0 + SYNC;
    done_c = dd + 1 + d + re * we + (re - 1) * ge;
    kill_e = (kill != 0) ? dd + kill_k + 1 : 32'h4000_0000;
    for (int k = 0; k < re; k++) begin
      st = dd + 1 + d + k * (we + ge);
      for (int j = 0; j < we; j++) begin
        if (st + j < kill_e) begin
          ev.c = st + j; ev.d = 1'b0;
          exp_q.push_back(ev);
        end
      end
    end
    if (kill == 0) begin
      ev.c = done_c; ev.d = 1'b1;
      exp_q.push_back(ev);
    end
    end_c = (kill != 0) ? kill_e + 2 : done_c + 2;
    while (cyc < end_c) begin
      @(negedge clk);
      abort = 1'b0; rst = 1'b0; arm = 1'b0;
      if (cyc == dd + 1 && kill_e > dd + 1) chk("busy_in_delay", busy, 1);
      if (kill == 0 && cyc == done_c) chk("busy_in_done", busy, 1);
      if (kill == 0 && cyc == done_c + 1) chk("busy_after_done", busy, 0);
      if (poke && kill == 0 && cyc == dd + 1) arm = 1'b1;
      // Re-trigger while busy must be ignored
      if (cyc == dd + 1) trig = 1'b0;
      if (cyc == dd + 3) trig = 1'b1;
      if (kill != 0 && cyc == dd + kill_k) begin
        if (kill == 1) abort = 1'b1;
        else rst = 1'b1;
      end
    end
    chk("idle_glitch", glitch, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    if (kill == 2) begin
      // Trigger without re-arm after reset must do nothing
      trig = 1'b0;
      repeat (3) @(negedge clk);
      trig = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_rearm_busy", busy, 0);
    end
    trig = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d, w, g, r, kill, kk, len;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    dly = '0; wid = '0; gap = '0; rep = '0;
    repeat (3) @(negedge clk);
    chk("rst_glitch", glitch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(3, 2, 0, 1, 0, 0, 1'b0, 1'b0);  // single pulse at E0+6..E0+7
    run_txn(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);  // all-zero programming
    run_txn(1, 1, 2, 3, 0, 0, 1'b0, 1'b1);  // 1,0,0,1,0,0,1 train, arm ignored
    run_txn(2, 1, 1, 2, 0, 0, 1'b1, 1'b0);  // trigger high before arm
    run_txn(2, 5, 1, 1, 1, 4, 1'b0, 1'b0);  // abort in 2nd pulse cycle
    run_txn(1, 1, 1, 1, 0, 0, 1'b0, 1'b0);  // re-arm after abort
    run_txn(1, 2, 3, 4, 2, 4, 1'b0, 1'b0);  // reset during first gap

    // Simultaneous arm and abort in IDLE: stays idle
    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0; trig = 1'b1;
    repeat (8) @(negedge clk);
    chk("arm_abort_busy", busy, 0);
    trig = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 6);
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 4);
      r = $urandom_range(0, 4);
      len = d + 1 + ((r == 0) ? 1 : r) * ((w == 0) ? 1 : w)
          + (((r == 0) ? 1 : r) - 1) * ((g == 0) ? 1 : g);
      kill = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      kk = $urandom_range(0, len - 1);
      run_txn(d, w, g, r, kill, kk, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
